ctl_data_demux: RTL and testbench

- Read-side engine of the convertible FIFO.
- Drains 72-bit words ({ctrl[7:0], data[63:0]}) from the FIFO BRAM.
- Packet mode: streams committed words to the downstream packet interface with out_wr/out_rdy flow control.
- CPU mode: serves addressed single-word reads, returning either the data field or the zero-extended ctrl byte.
- It is the inverse of the write-side ctl/data merge path.

---
 rtl/ctl_data_demux.sv | 181 ++++++++++++++++++
 tb/tb_ctl_data_demux.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctl_data_demux.sv
`default_nettype none
// ============================================================================
//  Module      : ctl_data_demux
//  Description : Read-side engine of the convertible FIFO. Drains 72-bit
//                {ctrl, data} words from the FIFO BRAM. In packet mode it
//                streams committed words downstream through a 2-entry skid
//                buffer. In CPU mode it serves addressed single-word reads,
//                returning either the data field or the zero-extended ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctl_data_demux #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             mode,
    input  logic [ADDR_WIDTH-1:0]            commit_ptr,
    output logic                             mem_rd_en,
    output logic [ADDR_WIDTH-1:0]            mem_rd_addr,
    input  logic [CTRL_WIDTH+DATA_WIDTH-1:0] mem_rd_data,
    output logic [ADDR_WIDTH-1:0]            rd_ptr,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]            out_ctrl,
    output logic                             out_wr,
    input  logic                             out_rdy,
    input  logic                             cpu_rd_req,
    input  logic [ADDR_WIDTH-1:0]            cpu_addr,
    input  logic                             cpu_field,
    output logic [DATA_WIDTH-1:0]            cpu_rd_data,
    output logic                             cpu_rd_valid,
    output logic                             pkt_sent,
    output logic [15:0]                      pkt_cnt
);

    localparam int c_WORD_W = CTRL_WIDTH + DATA_WIDTH;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] rd_ptr_q,         rd_ptr_d;
    logic [c_WORD_W-1:0]   buf_q [2];
    logic                  head_q,           head_d;
    logic [1:0]            occ_q,            occ_d;
    logic                  in_flight_q,      in_flight_d;
    logic                  cpu_pend_q,       cpu_pend_d;
    logic                  cpu_field_q,      cpu_field_d;
    logic [DATA_WIDTH-1:0] cpu_rd_data_q,    cpu_rd_data_d;
    logic                  cpu_rd_valid_q,   cpu_rd_valid_d;
    logic                  prev_ctrl_zero_q, prev_ctrl_zero_d;
    logic                  pkt_sent_q,       pkt_sent_d;
    logic [15:0]           pkt_cnt_q,        pkt_cnt_d;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic [c_WORD_W-1:0]   w_head;
    logic [CTRL_WIDTH-1:0] w_head_ctrl;
    logic                  w_empty;
    logic                  w_xfer;
    logic [2:0]            w_level;
    logic                  w_issue;
    logic                  w_cpu_accept;
    logic                  w_wr_idx;
    logic                  w_eop;
    logic [DATA_WIDTH-1:0] w_ctrl_ext;

    assign w_head      = buf_q[head_q];
    assign w_head_ctrl = w_head[c_WORD_W-1 -: CTRL_WIDTH];
    assign w_empty     = (rd_ptr_q == commit_ptr);

    // A transfer happens whenever a word is buffered, downstream is ready
    // and we are streaming.
    assign w_xfer = (occ_q != 2'd0) & out_rdy & ~mode;

    // Words committed to the buffer after this cycle: buffered plus the one
    // landing, minus the one leaving. Must stay below 2 to issue another.
    assign w_level = {1'b0, occ_q} + {2'b00, in_flight_q} - {2'b00, w_xfer};

    // Reset gating keeps the BRAM strobe quiet while the block is held.
    assign w_issue      = reset_n & ~mode & ~w_empty & (w_level < 3'd2);
    assign w_cpu_accept = reset_n & mode & cpu_rd_req & ~in_flight_q;

    // Landing word goes directly behind the current head (never when full,
    // because an in-flight read implies at most one buffered word).
    assign w_wr_idx = head_q ^ occ_q[0];

    // End of packet: non-zero ctrl following a zero-ctrl word.
    assign w_eop = w_xfer & (w_head_ctrl != '0) & prev_ctrl_zero_q;

    assign w_ctrl_ext = {{(DATA_WIDTH-CTRL_WIDTH){1'b0}},
                         mem_rd_data[c_WORD_W-1 -: CTRL_WIDTH]};

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign mem_rd_en    = w_issue | w_cpu_accept;
    assign mem_rd_addr  = w_cpu_accept ? cpu_addr : rd_ptr_q;
    assign rd_ptr       = rd_ptr_q;
    assign out_data     = w_head[DATA_WIDTH-1:0];
    assign out_ctrl     = w_head_ctrl;
    assign out_wr       = w_xfer;
    assign cpu_rd_data  = cpu_rd_data_q;
    assign cpu_rd_valid = cpu_rd_valid_q;
    assign pkt_sent     = pkt_sent_q;
    assign pkt_cnt      = pkt_cnt_q;

    // Next-state for pointers, buffer occupancy, CPU return path and EOP count.
    always_comb begin
        rd_ptr_d         = rd_ptr_q;
        head_d           = head_q ^ w_xfer;
        occ_d            = occ_q;
        in_flight_d      = w_issue;
        cpu_pend_d       = w_cpu_accept;
        cpu_field_d      = w_cpu_accept ? cpu_field : cpu_field_q;
        cpu_rd_data_d    = cpu_rd_data_q;
        cpu_rd_valid_d   = cpu_pend_q;
        prev_ctrl_zero_d = prev_ctrl_zero_q;
        pkt_sent_d       = w_eop;
        pkt_cnt_d        = pkt_cnt_q;

        if (w_issue) begin
            rd_ptr_d = rd_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end

        if (in_flight_q & ~w_xfer) begin
            occ_d = occ_q + 2'd1;
        end else if (~in_flight_q & w_xfer) begin
            occ_d = occ_q - 2'd1;
        end

        if (cpu_pend_q) begin
            cpu_rd_data_d = cpu_field_q ? w_ctrl_ext : mem_rd_data[DATA_WIDTH-1:0];
        end

        if (w_xfer) begin
            prev_ctrl_zero_d = (w_head_ctrl == '0);
        end

        if (w_eop) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
    end

    // State registers; reset discards buffered and in-flight words.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q         <= '0;
            buf_q[0]         <= '0;
            buf_q[1]         <= '0;
            head_q           <= 1'b0;
            occ_q            <= 2'd0;
            in_flight_q      <= 1'b0;
            cpu_pend_q       <= 1'b0;
            cpu_field_q      <= 1'b0;
            cpu_rd_data_q    <= '0;
            cpu_rd_valid_q   <= 1'b0;
            prev_ctrl_zero_q <= 1'b0;
            pkt_sent_q       <= 1'b0;
            pkt_cnt_q        <= 16'd0;
        end else begin
            rd_ptr_q         <= rd_ptr_d;
            head_q           <= head_d;
            occ_q            <= occ_d;
            in_flight_q      <= in_flight_d;
            cpu_pend_q       <= cpu_pend_d;
            cpu_field_q      <= cpu_field_d;
            cpu_rd_data_q    <= cpu_rd_data_d;
            cpu_rd_valid_q   <= cpu_rd_valid_d;
            prev_ctrl_zero_q <= prev_ctrl_zero_d;
            pkt_sent_q       <= pkt_sent_d;
            pkt_cnt_q        <= pkt_cnt_d;
            if (in_flight_q) begin
                buf_q[w_wr_idx] <= mem_rd_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ctl_data_demux.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ctl_data_demux
//  Description : Self-checking bench for ctl_data_demux with a BRAM model,
//                stream/CPU scoreboards and directed corner-case sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ctl_data_demux;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [63:0] data;
    } word_t;

    typedef struct {
        logic [7:0]  addr;
        logic        field;
        logic [63:0] exp;
    } cpu_vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mode;
    logic [7:0]  commit_ptr;
    logic        mem_rd_en;
    logic [7:0]  mem_rd_addr;
    logic [71:0] mem_rd_data;
    logic [7:0]  rd_ptr;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic        cpu_rd_req;
    logic [7:0]  cpu_addr;
    logic        cpu_field;
    logic [63:0] cpu_rd_data;
    logic        cpu_rd_valid;
    logic        pkt_sent;
    logic [15:0] pkt_cnt;

    always #5 clk = ~clk;

    ctl_data_demux #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (64),
        .CTRL_WIDTH (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mode         (mode),
        .commit_ptr   (commit_ptr),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .rd_ptr       (rd_ptr),
        .out_data     (out_data),
        .out_ctrl     (out_ctrl),
        .out_wr       (out_wr),
        .out_rdy      (out_rdy),
        .cpu_rd_req   (cpu_rd_req),
        .cpu_addr     (cpu_addr),
        .cpu_field    (cpu_field),
        .cpu_rd_data  (cpu_rd_data),
        .cpu_rd_valid (cpu_rd_valid),
        .pkt_sent     (pkt_sent),
        .pkt_cnt      (pkt_cnt)
    );

    // BRAM model: one cycle read latency
    logic [71:0] mem [256];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboards and bookkeeping
    logic [71:0] exp_words[$];
    logic [7:0]  exp_addrs[$];
    logic [63:0] exp_cpu[$];
    logic [7:0]  model_ptr = 8'd0;
    int checks = 0;
    int fails  = 0;
    int outstanding = 0;
    int first_x = -1, last_x = -1;
    int cpu_first = -1, cpu_last = -1;
    int cpu_resps = 0;
    int pkt_pulses = 0;
    bit mon_en = 1'b0;

    word_t    pkts [2][5];
    cpu_vec_t cv   [4];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pkt(input logic [7:0] base, input int k);
        for (int i = 0; i < 5; i++) begin
            logic [7:0] a;
            a = base + 8'(i);
            mem[a] = {pkts[k][i].ctrl, pkts[k][i].data ^ {56'd0, a}};
        end
    endtask

    task automatic commit_to(input logic [7:0] p);
        while (model_ptr != p) begin
            exp_addrs.push_back(model_ptr);
            exp_words.push_back(mem[model_ptr]);
            model_ptr = model_ptr + 8'd1;
        end
        commit_ptr = p;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_words.size() != 0 || exp_addrs.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk(tag, 72'(exp_words.size() + exp_addrs.size()), 72'd0);
        repeat (2) step();
    endtask

    // Monitor: samples on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (!reset_n) begin
            outstanding = 0;
        end else if (mon_en) begin
            if (out_wr) begin
                chk("out_wr_qualifiers", {70'd0, out_rdy, mode}, 72'b10);
                if (exp_words.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL stream_word: got unexpected %0h expected none", {out_ctrl, out_data});
                end else begin
                    chk("stream_word", {out_ctrl, out_data}, exp_words.pop_front());
                end
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
            end
            if (mem_rd_en && !mode) begin
                if (exp_addrs.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL stream_addr: got unexpected read %0d expected none", mem_rd_addr);
                end else begin
                    chk("stream_addr", {64'd0, mem_rd_addr}, {64'd0, exp_addrs.pop_front()});
                end
            end
            chk("occupancy_le_2", {71'd0, outstanding <= 2}, 72'd1);
            outstanding = outstanding + int'(mem_rd_en && !mode) - int'(out_wr);
            if (cpu_rd_valid) begin
                cpu_resps++;
                if (cpu_first < 0) cpu_first = cyc;
                cpu_last = cyc;
                if (exp_cpu.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL cpu_rd_data: got unexpected %0h expected none", cpu_rd_data);
                end else begin
                    chk("cpu_rd_data", {8'd0, cpu_rd_data}, {8'd0, exp_cpu.pop_front()});
                end
            end
            if (pkt_sent) pkt_pulses++;
        end
    end

    initial begin
        int req_cyc;
        int resp_before;

        pkts[0][0] = '{8'hFF, 64'h4844_5200_0000_0000};
        pkts[0][1] = '{8'h00, 64'hD1D1_0000_1111_0000};
        pkts[0][2] = '{8'h00, 64'hD2D2_0000_2222_0000};
        pkts[0][3] = '{8'h00, 64'hD3D3_0000_3333_0000};
        pkts[0][4] = '{8'h40, 64'hD4D4_0000_4444_0000};
        pkts[1][0] = '{8'h00, 64'hE0E0_5555_0000_0000};
        pkts[1][1] = '{8'h00, 64'hE1E1_5555_0000_0000};
        pkts[1][2] = '{8'h00, 64'hE2E2_5555_0000_0000};
        pkts[1][3] = '{8'h00, 64'hE3E3_5555_0000_0000};
        pkts[1][4] = '{8'h80, 64'hE4E4_5555_0000_0000};

        cv[0] = '{8'd3,   1'b1, 64'h0000_0000_0000_0040};
        cv[1] = '{8'd3,   1'b0, 64'hD3D3_D3D3_D3D3_D3D3};
        cv[2] = '{8'd200, 1'b1, 64'h0000_0000_0000_00A5};
        cv[3] = '{8'd200, 1'b0, 64'h0123_4567_89AB_CDEF};

        for (int i = 0; i < 256; i++) mem[i] = 72'd0;
        mem_rd_data = 72'd0;
        reset_n = 1'b0; mode = 1'b0; commit_ptr = 8'd0; out_rdy = 1'b0;
        cpu_rd_req = 1'b0; cpu_addr = 8'd0; cpu_field = 1'b0;

        repeat (3) step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_rd_ptr",       {64'd0, rd_ptr},       72'd0);
        chk("rst_out_wr",       {71'd0, out_wr},       72'd0);
        chk("rst_out_word",     {out_ctrl, out_data},  72'd0);
        chk("rst_cpu_rd_data",  {8'd0, cpu_rd_data},   72'd0);
        chk("rst_cpu_rd_valid", {71'd0, cpu_rd_valid}, 72'd0);
        chk("rst_pkt_sent",     {71'd0, pkt_sent},     72'd0);
        chk("rst_pkt_cnt",      {56'd0, pkt_cnt},      72'd0);
        chk("rst_mem_rd_en",    {71'd0, mem_rd_en},    72'd0);
        mon_en = 1'b1;

        // Stream one packet with downstream always ready
        load_pkt(8'd0, 0);
        out_rdy = 1'b1;
        step();
        first_x = -1;
        req_cyc = cyc;
        commit_to(8'd5);
        wait_drain("stream_drain", 40);
        chk("stream_latency",    72'(first_x - req_cyc), 72'd2);
        chk("stream_contiguous", 72'(last_x - first_x),  72'd4);
        chk("stream_rd_ptr",     {64'd0, rd_ptr},        72'd5);
        chk("stream_pkt_cnt",    {56'd0, pkt_cnt},       72'd1);
        chk("stream_pkt_pulses", 72'(pkt_pulses),        72'd1);

        // Backpressure: out_rdy 1,0,0 repeating
        load_pkt(8'd5, 0);
        commit_to(8'd10);
        for (int i = 0; i < 30; i++) begin
            out_rdy = (i % 3 == 0);
            step();
        end
        out_rdy = 1'b1;
        wait_drain("bp_drain", 40);
        chk("bp_rd_ptr",     {64'd0, rd_ptr},  72'd10);
        chk("bp_pkt_cnt",    {56'd0, pkt_cnt}, 72'd2);
        chk("bp_pkt_pulses", 72'(pkt_pulses),  72'd2);

        // Pointer wrap: advance to 254, then across the top to 2
        for (int a = 10; a < 254; a++) mem[a] = {8'h00, 64'hC0DE_0000_0000_0000 | 64'(a)};
        commit_to(8'd254);
        wait_drain("fill_drain", 300);
        chk("fill_rd_ptr", {64'd0, rd_ptr}, 72'd254);
        mem[254] = {8'h00, 64'hAAAA_0000_0000_00FE};
        mem[255] = {8'h00, 64'hAAAA_0000_0000_00FF};
        mem[0]   = {8'h00, 64'hAAAA_0000_0000_0000};
        mem[1]   = {8'h02, 64'hAAAA_0000_0000_0001};
        commit_to(8'd2);
        wait_drain("wrap_drain", 20);
        chk("wrap_rd_ptr",  {64'd0, rd_ptr},  72'd2);
        chk("wrap_pkt_cnt", {56'd0, pkt_cnt}, 72'd3);

        // CPU reads, back to back, table driven
        mem[3]   = {8'h40, 64'hD3D3_D3D3_D3D3_D3D3};
        mem[200] = {8'hA5, 64'h0123_4567_89AB_CDEF};
        mode = 1'b1;
        step();
        cpu_first = -1;
        req_cyc = cyc;
        for (int i = 0; i < 4; i++) begin
            cpu_rd_req = 1'b1;
            cpu_addr   = cv[i].addr;
            cpu_field  = cv[i].field;
            exp_cpu.push_back(cv[i].exp);
            step();
        end
        cpu_rd_req = 1'b0;
        for (int n = 0; n < 10 && exp_cpu.size() != 0; n++) step();
        chk("cpu_all_returned", 72'(exp_cpu.size()),        72'd0);
        chk("cpu_latency",      72'(cpu_first - req_cyc),   72'd2);
        chk("cpu_back_to_back", 72'(cpu_last - cpu_first),  72'd3);
        chk("cpu_rd_ptr",       {64'd0, rd_ptr},            72'd2);

        // CPU request in packet mode gets no response
        mode = 1'b0;
        resp_before = cpu_resps;
        cpu_rd_req = 1'b1; cpu_addr = 8'd3; cpu_field = 1'b1;
        step();
        cpu_rd_req = 1'b0;
        repeat (4) step();
        chk("cpu_ignored_mode0", 72'(cpu_resps - resp_before), 72'd0);

        // Mode switch with one word buffered and one in flight
        load_pkt(8'd2, 1);
        out_rdy = 1'b0;
        commit_to(8'd7);
        step();
        step();
        mode = 1'b1;
        resp_before = cpu_resps;
        cpu_rd_req = 1'b1; cpu_addr = 8'd3; cpu_field = 1'b0;
        step();
        cpu_rd_req = 1'b0;
        out_rdy = 1'b1;
        repeat (5) step();
        chk("switch_held_words", 72'(exp_words.size()),       72'd5);
        chk("switch_rd_ptr",     {64'd0, rd_ptr},             72'd4);
        chk("switch_cpu_busy",   72'(cpu_resps - resp_before), 72'd0);
        mode = 1'b0;
        wait_drain("switch_drain", 30);
        chk("switch_rd_ptr_end", {64'd0, rd_ptr},  72'd7);
        chk("switch_pkt_cnt",    {56'd0, pkt_cnt}, 72'd4);

        // Asynchronous reset mid-packet
        load_pkt(8'd7, 0);
        commit_to(8'd12);
        step(); step(); step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_rd_ptr",       {64'd0, rd_ptr},       72'd0);
        chk("arst_out_wr",       {71'd0, out_wr},       72'd0);
        chk("arst_out_word",     {out_ctrl, out_data},  72'd0);
        chk("arst_cpu_rd_data",  {8'd0, cpu_rd_data},   72'd0);
        chk("arst_cpu_rd_valid", {71'd0, cpu_rd_valid}, 72'd0);
        chk("arst_pkt_sent",     {71'd0, pkt_sent},     72'd0);
        chk("arst_pkt_cnt",      {56'd0, pkt_cnt},      72'd0);
        commit_ptr = 8'd0;
        model_ptr  = 8'd0;
        exp_words.delete();
        exp_addrs.delete();
        step(); step();
        reset_n = 1'b1;
        step();
        load_pkt(8'd0, 0);
        commit_to(8'd3);
        wait_drain("post_rst_drain", 20);
        chk("post_rst_rd_ptr",  {64'd0, rd_ptr},  72'd3);
        chk("post_rst_pkt_cnt", {56'd0, pkt_cnt}, 72'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
